// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: funct3 codes, memory op codes,
// FSM state encoding and small decode helpers.
package dmem_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [1:0] RWE_RD = 2'd0;
   localparam logic [1:0] RWE_SW = 2'd1;
   localparam logic [1:0] RWE_SH = 2'd2;
   localparam logic [1:0] RWE_SB = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_LOAD_CAP = 3'd2,
      ST_STORE    = 3'd3,
      ST_RESP     = 3'd4
   } state_e;

   // Access size in bytes; funct3[1:0]=3 reports 4 but is rejected elsewhere.
   function automatic logic [2:0] access_size(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [1:0] store_rwe(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return RWE_SB;
         2'd1:    return RWE_SH;
         default: return RWE_SW;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lsu_load_extend.sv
// Selects the byte/halfword/word from the memory read data and sign- or zero-extends
// it according to the load funct3.
module load_extend
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [2:0]  funct3,
   output logic [31:0] ext_data
);

   always_comb begin
      ext_data = mem_rdata;
      case (funct3)
         F3_B:    ext_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         F3_BU:   ext_data = {24'd0, mem_rdata[7:0]};
         F3_H:    ext_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         F3_HU:   ext_data = {16'd0, mem_rdata[15:0]};
         default: ext_data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store initiator for the byte-addressed data memory. Range and
// alignment faults are resolved at accept, so a faulting access never touches memory.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int MEM_BYTES = 128,
   parameter int ADDR_W    = 7,
   parameter bit ALIGN_CHK = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        mem_rwe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);

   localparam logic [32:0] MEM_LIM = 33'(MEM_BYTES);

   state_e            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic [1:0]        mem_rwe_q, mem_rwe_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic [2:0]  req_size;
   logic [32:0] req_end;
   logic        range_flt, align_flt, f3_flt, req_flt;
   logic [31:0] ld_ext;

   load_extend u_load_extend (
      .mem_rdata (mem_rdata),
      .funct3    (funct3_q),
      .ext_data  (ld_ext)
   );

   // 33-bit end address so an access near 2^32 cannot wrap back into range.
   always_comb begin
      req_size  = access_size(req_funct3);
      req_end   = {1'b0, req_addr} + {30'd0, req_size};
      range_flt = (req_end > MEM_LIM);
      align_flt = 1'b0;
      if (ALIGN_CHK) begin
         case (req_size)
            3'd2:    align_flt = req_addr[0];
            3'd4:    align_flt = |req_addr[1:0];
            default: align_flt = 1'b0;
         endcase
      end
      f3_flt  = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7) ||
                (req_we && (req_funct3 >= 3'd3));
      req_flt = range_flt || align_flt || f3_flt;
   end

   always_comb begin
      state_d     = state_q;
      funct3_d    = funct3_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_rwe_d   = RWE_RD;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               funct3_d    = req_funct3;
               rsp_rdata_d = 32'd0;
               rsp_err_d   = 1'b0;
               if (req_flt) begin
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  state_d     = ST_RESP;
               end else if (req_we) begin
                  mem_rwe_d   = store_rwe(req_funct3);
                  mem_addr_d  = req_addr[ADDR_W-1:0];
                  mem_wdata_d = req_wdata;
                  state_d     = ST_STORE;
               end else begin
                  mem_addr_d  = req_addr[ADDR_W-1:0];
                  state_d     = ST_LOAD;
               end
            end
         end
         ST_LOAD: state_d = ST_LOAD_CAP;
         ST_LOAD_CAP: begin
            rsp_rdata_d = ld_ext;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_STORE: begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         funct3_q    <= 3'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
         mem_rwe_q   <= RWE_RD;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         funct3_q    <= funct3_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         mem_rwe_q   <= mem_rwe_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_rwe   = mem_rwe_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: a driver pushes model-predicted responses, a negedge
// monitor pops and compares them; a behavioural 128-byte memory sits on the mem port.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  mem_rwe;
   logic [6:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        busy;

   dmem_lsu dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_rwe(mem_rwe), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          sz;
      logic [1:0]  rwe;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   npass = 0;
   int   nchk  = 0;
   int   cyc   = 0;
   int   rwe_seen = 0;
   int   bp_cnt = 0;
   bit   rand_bp = 0;

   // Device memory: little-endian bytes, read data registered one cycle after the address.
   logic [7:0] dev_mem [128] = '{0: 8'h05, 4: 8'h10, default: 8'h00};
   logic [7:0] ref_mem [128] = '{0: 8'h05, 4: 8'h10, default: 8'h00};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      mem_rdata <= {dev_mem[(int'(mem_addr)+3)%128], dev_mem[(int'(mem_addr)+2)%128],
                    dev_mem[(int'(mem_addr)+1)%128], dev_mem[int'(mem_addr)]};
      case (mem_rwe)
         2'd3: dev_mem[mem_addr] <= mem_wdata[7:0];
         2'd2: begin
            dev_mem[mem_addr] <= mem_wdata[7:0];
            dev_mem[(int'(mem_addr)+1)%128] <= mem_wdata[15:8];
         end
         2'd1: begin
            dev_mem[mem_addr] <= mem_wdata[7:0];
            dev_mem[(int'(mem_addr)+1)%128] <= mem_wdata[15:8];
            dev_mem[(int'(mem_addr)+2)%128] <= mem_wdata[23:16];
            dev_mem[(int'(mem_addr)+3)%128] <= mem_wdata[31:24];
         end
         default: ;
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic exp_t model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata);
      exp_t   e;
      longint a;
      longint v;
      e.we = we; e.f3 = f3; e.addr = addr; e.wdata = wdata; e.acc = 0;
      e.sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      a = {32'd0, addr};
      e.err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 > 3'd2) ||
              (a >= 128) || (a + e.sz > 128) || ((a % e.sz) != 0);
      e.lat = e.err ? 1 : (we ? 2 : 3);
      e.rwe = (e.err || !we) ? 2'd0 : (e.sz == 1) ? 2'd3 : (e.sz == 2) ? 2'd2 : 2'd1;
      e.rdata = 32'd0;
      if (!e.err && !we) begin
         v = 0;
         for (int i = 0; i < e.sz; i++) v = v | (longint'(ref_mem[int'(a) + i]) << (8 * i));
         if (f3 < 3'd4 && v[8*e.sz-1]) v = v | ~((64'sd1 << (8 * e.sz)) - 1);
         e.rdata = v[31:0];
      end
      return e;
   endfunction

   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      int   n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         nchk++;
         $display("FAIL req_ready_timeout: got 0 expected 1 (t=%0t)", $time);
         return;
      end
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      @(posedge clk);
      #1;
      e = model(we, f3, addr, wdata);
      e.acc = cyc;
      rwe_seen = 0;
      q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic chk_reset();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err",   32'(rsp_err), 32'd0);
      chk("rst_mem_rwe",   32'(mem_rwe), 32'd0);
      chk("rst_mem_addr",  32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_busy",      32'(busy), 32'd0);
   endtask

   task automatic abort_with_reset();
      #2 reset = 1'b1;
      #1 chk_reset();
      q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   // Consumer: optional forced stall, otherwise always-ready or random.
   initial forever begin
      @(posedge clk);
      #2;
      if (bp_cnt > 0) begin
         rsp_ready = 1'b0;
         if (rsp_valid) bp_cnt--;
      end else begin
         rsp_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Monitor
   initial begin
      bit          prev_v = 0;
      bit          idle_due = 0;
      logic [31:0] last_rdata = 0;
      logic        last_err = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("rwe_during_reset", 32'(mem_rwe), 32'd0);
            prev_v = 0;
            idle_due = 0;
         end else begin
            if (mem_rwe != 2'd0) begin
               if (q.size() == 0) begin
                  nchk++;
                  $display("FAIL stray_mem_write: got rwe %0d expected 0", mem_rwe);
               end else begin
                  chk("mem_rwe", 32'(mem_rwe), 32'(q[0].rwe));
                  chk("mem_addr", 32'(mem_addr), 32'(q[0].addr[6:0]));
                  chk("mem_wdata", mem_wdata, q[0].wdata);
                  rwe_seen++;
               end
            end
            if (idle_due) begin
               chk("req_ready_after_rsp", 32'(req_ready), 32'd1);
               chk("rsp_valid_after_rsp", 32'(rsp_valid), 32'd0);
               idle_due = 0;
            end
            if (rsp_valid) begin
               if (q.size() == 0) begin
                  nchk++;
                  $display("FAIL unexpected_rsp: got rsp_valid 1 expected 0 (t=%0t)", $time);
               end else begin
                  if (!prev_v) chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat - 1));
                  else begin
                     chk("rdata_stable", rsp_rdata, last_rdata);
                     chk("err_stable", 32'(rsp_err), 32'(last_err));
                  end
                  chk("req_ready_busy", 32'(req_ready), 32'd0);
                  last_rdata = rsp_rdata;
                  last_err   = rsp_err;
                  if (rsp_ready) begin
                     chk("rsp_rdata", rsp_rdata, q[0].rdata);
                     chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
                     chk("rwe_pulses", 32'(rwe_seen), (q[0].rwe != 2'd0) ? 32'd1 : 32'd0);
                     if (q[0].we && !q[0].err)
                        for (int i = 0; i < q[0].sz; i++)
                           ref_mem[int'(q[0].addr) + i] = q[0].wdata[8*i +: 8];
                     void'(q.pop_front());
                     idle_due = 1;
                  end
               end
            end
            prev_v = rsp_valid;
         end
      end
   end

   initial begin
      int n;
      #1 reset = 1'b1;
      #1 chk_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;

      issue(0, 3'd2, 32'd0, 32'd0);
      issue(0, 3'd2, 32'd4, 32'd0);
      issue(1, 3'd0, 32'd9, 32'h1FF);
      issue(0, 3'd0, 32'd9, 32'd0);
      issue(0, 3'd4, 32'd9, 32'd0);
      issue(1, 3'd1, 32'd2, 32'h8001);
      issue(0, 3'd1, 32'd2, 32'd0);
      issue(0, 3'd5, 32'd2, 32'd0);
      issue(0, 3'd2, 32'd0, 32'd0);
      issue(0, 3'd2, 32'd126, 32'd0);
      issue(0, 3'd2, 32'd6, 32'd0);
      issue(1, 3'd2, 32'h80, 32'h12345678);
      issue(1, 3'd3, 32'd0, 32'hDEADBEEF);
      issue(0, 3'd0, 32'hFFFFFFFF, 32'd0);
      issue(0, 3'd6, 32'd0, 32'd0);

      bp_cnt = 5;
      issue(0, 3'd2, 32'd4, 32'd0);
      issue(0, 3'd2, 32'd0, 32'd0);

      issue(0, 3'd2, 32'd0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      abort_with_reset();
      issue(1, 3'd2, 32'd8, 32'hCAFEF00D);
      abort_with_reset();
      issue(0, 3'd2, 32'd8, 32'd0);

      rand_bp = 1;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 131));
         issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end

      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         nchk++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      end
      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
